// File: rtl/jtdsp16_do_ctrl_if.sv
// Decoder <-> do-loop sequencer bus: decoded DO/REDO requests in, loop
// control strobes and cached instruction index out.
interface jtdsp16_do_ctrl_if;
    logic        do_en;
    logic        redo_en;
    logic [10:0] do_data;
    logic        do_start;
    logic        do_save;
    logic        do_redo;
    logic        do_out;
    logic        do_short;
    logic [3:0]  do_pc;
    logic        busy;

    modport master (
        output do_en, redo_en, do_data,
        input  do_start, do_save, do_redo, do_out, do_short, do_pc, busy
    );

    modport slave (
        input  do_en, redo_en, do_data,
        output do_start, do_save, do_redo, do_out, do_short, do_pc, busy
    );
endinterface

// File: rtl/jtdsp16_do_ctrl.sv
// Do-loop sequencer: decodes DO/REDO and replays up to 15 cached
// instructions up to 127 times by stepping the cache index on cen.
//
// state | meaning
// IDLE  | no loop active; DO/REDO requests are accepted
// LOOP  | replaying cached instructions; requests are ignored
module jtdsp16_do_ctrl (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    jtdsp16_do_ctrl_if.slave bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOOP = 1'b1;

    logic [0:0] st,       st_nx;
    logic [3:0] ni_r,     ni_nx;
    logic [6:0] k_cnt,    k_nx;
    logic [3:0] pc,       pc_nx;
    logic       start_r,  start_nx;
    logic       save_r,   save_nx;
    logic       redo_r,   redo_nx;
    logic       out_r,    out_nx;
    logic       short_r,  short_nx;
    logic       zero_nx;
    logic [3:0] ni_field;
    logic [6:0] k_field;
    logic [6:0] k_load;

    assign ni_field = bus.do_data[10:7];
    assign k_field  = bus.do_data[6:0];
    // K of 0 and 1 both mean one pass through the cached block
    assign k_load   = (k_field <= 7'd1) ? 7'd1 : k_field;

    always_comb begin
        st_nx    = st;
        ni_nx    = ni_r;
        k_nx     = k_cnt;
        pc_nx    = pc;
        start_nx = 1'b0;
        save_nx  = 1'b0;
        redo_nx  = 1'b0;
        zero_nx  = 1'b0;
        if (st == IDLE) begin
            if (bus.do_en) begin
                ni_nx = ni_field;
                k_nx  = k_load;
                if (ni_field == 4'd0) begin
                    zero_nx = 1'b1;
                end else begin
                    st_nx    = LOOP;
                    start_nx = 1'b1;
                    save_nx  = 1'b1;
                    pc_nx    = 4'd0;
                end
            end else if (bus.redo_en) begin
                k_nx = k_load;
                if (ni_r != 4'd0) begin
                    st_nx    = LOOP;
                    start_nx = 1'b1;
                    save_nx  = 1'b1;
                    redo_nx  = 1'b1;
                    pc_nx    = 4'd0;
                end
            end
        end else begin
            if (pc == ni_r - 4'd1) begin
                pc_nx = 4'd0;
                if (k_cnt == 7'd1) st_nx = IDLE;
                else               k_nx  = k_cnt - 7'd1;
            end else begin
                pc_nx = pc + 4'd1;
            end
        end
        // do_out is raised on the fetch of the last instruction of the last pass
        out_nx   = zero_nx |
                   ((st_nx == LOOP) && (pc_nx == ni_nx - 4'd1) && (k_nx == 7'd1));
        short_nx = (st_nx == LOOP) && (ni_nx == 4'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= IDLE;
            ni_r    <= 4'd0;
            k_cnt   <= 7'd0;
            pc      <= 4'd0;
            start_r <= 1'b0;
            save_r  <= 1'b0;
            redo_r  <= 1'b0;
            out_r   <= 1'b0;
            short_r <= 1'b0;
        end else if (cen) begin
            st      <= st_nx;
            ni_r    <= ni_nx;
            k_cnt   <= k_nx;
            pc      <= pc_nx;
            start_r <= start_nx;
            save_r  <= save_nx;
            redo_r  <= redo_nx;
            out_r   <= out_nx;
            short_r <= short_nx;
        end
    end

    assign bus.do_start = start_r;
    assign bus.do_save  = save_r;
    assign bus.do_redo  = redo_r;
    assign bus.do_out   = out_r;
    assign bus.do_short = short_r;
    assign bus.do_pc    = pc;
    assign bus.busy     = (st == LOOP);

endmodule

// File: tb/tb_jtdsp16_do_ctrl.sv
// Scoreboard bench for the do-loop sequencer: a trace model expands each
// accepted DO/REDO into its per-cen-cycle output records.
module tb_jtdsp16_do_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic cen;

    jtdsp16_do_ctrl_if bus();

    jtdsp16_do_ctrl dut (
        .clk (clk),
        .rst (rst),
        .cen (cen),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [10:0] exp_q[$];
    int          loop_left = 0;
    logic [3:0]  ni_m = 4'd0;
    logic        edge_cen = 1'b0;
    logic        in_rst = 1'b1;
    logic [10:0] prev_obs = 11'd0;

    // {busy, start, save, redo, out, short, pc}
    function automatic logic [10:0] obs();
        return {bus.busy, bus.do_start, bus.do_save, bus.do_redo,
                bus.do_out, bus.do_short, bus.do_pc};
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b expected %b (busy,start,save,redo,out,short,pc[3:0])",
                     name, $time, act, exp);
        end
    endtask

    task automatic push_loop(input int ni, input int k, input logic redo);
        int kk;
        int n;
        kk = (k <= 1) ? 1 : k;
        n  = ni * kk;
        for (int i = 0; i < n; i++)
            exp_q.push_back({1'b1, 1'(i == 0), 1'(i == 0), 1'(redo && i == 0),
                             1'(i == n - 1), 1'(ni == 1), 4'(i % ni)});
        loop_left = n;
    endtask

    task automatic model_step(input logic de, input logic re, input logic [10:0] data);
        if (loop_left > 0) begin
            loop_left--;
        end else if (de) begin
            ni_m = data[10:7];
            if (ni_m == 4'd0) exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0});
            else              push_loop(int'(ni_m), int'(data[6:0]), 1'b0);
        end else if (re && ni_m != 4'd0) begin
            push_loop(int'(ni_m), int'(data[6:0]), 1'b1);
        end
    endtask

    task automatic cyc(input logic c, input logic de, input logic re, input logic [10:0] data);
        bus.do_en   = de;
        bus.redo_en = re;
        bus.do_data = data;
        cen         = c;
        @(posedge clk);
        edge_cen = c;
        if (c && !rst) model_step(de, re, data);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b1, 1'b0, 1'b0, 11'd0);
    endtask

    task automatic do_cmd(input logic [3:0] ni, input logic [6:0] k);
        cyc(1'b1, 1'b1, 1'b0, {ni, k});
    endtask

    task automatic redo_cmd(input logic [6:0] k);
        cyc(1'b1, 1'b0, 1'b1, {4'd0, k});
    endtask

    // asynchronous reset asserted between edges, outputs checked before any edge
    task automatic reset_mid();
        #1;
        rst    = 1'b1;
        in_rst = 1'b1;
        #1;
        check("rst_async", obs(), 11'd0);
        exp_q.delete();
        ni_m      = 4'd0;
        loop_left = 0;
        idle(2);
        rst    = 1'b0;
        in_rst = 1'b0;
        idle(1);
        check("idle_after_rst", obs(), 11'd0);
    endtask

    // monitor: pops an expected record whenever the DUT shows activity or one is due
    initial begin
        forever begin
            @(negedge clk);
            if (!in_rst) begin
                if (edge_cen) begin
                    if (exp_q.size() > 0)  check("trace", obs(), exp_q.pop_front());
                    else if (obs() != 11'd0) check("idle", obs(), 11'd0);
                end else begin
                    check("stall_hold", obs(), prev_obs);
                end
            end
            prev_obs = obs();
        end
    end

    initial begin
        int guard;
        logic c, de, re;
        logic [3:0] ni;
        logic [6:0] k;
        int r;

        rst         = 1'b1;
        cen         = 1'b0;
        bus.do_en   = 1'b0;
        bus.redo_en = 1'b0;
        bus.do_data = 11'd0;
        idle(3);
        check("reset", obs(), 11'd0);
        rst    = 1'b0;
        in_rst = 1'b0;
        idle(2);

        do_cmd(4'd3, 7'd2);  idle(10);
        do_cmd(4'd1, 7'd4);  idle(6);
        do_cmd(4'd2, 7'd2);  idle(6);  redo_cmd(7'd3);  idle(9);
        reset_mid();         redo_cmd(7'd5);  idle(3);
        do_cmd(4'd4, 7'd3);  idle(3);  do_cmd(4'd5, 7'd5);  redo_cmd(7'd2);  idle(10);
        do_cmd(4'd0, 7'd9);  idle(3);
        do_cmd(4'd5, 7'd3);
        repeat (40) cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0, 11'd0);
        idle(20);
        do_cmd(4'd6, 7'd5);  idle(7);  reset_mid();  redo_cmd(7'd4);  idle(5);
        do_cmd(4'd3, 7'd0);  idle(5);
        cyc(1'b1, 1'b1, 1'b1, {4'd2, 7'd2});  idle(8);
        do_cmd(4'd15, 7'd127);  idle(1910);

        repeat (6000) begin
            c  = ($urandom % 4) != 0;
            r  = $urandom % 16;
            de = (r == 0);
            re = (r == 1);
            ni = 4'($urandom % 16);
            k  = (($urandom % 8) == 0) ? 7'($urandom % 128) : 7'($urandom % 6);
            cyc(c, de, re, {ni, k});
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 4000) begin
            idle(1);
            guard++;
        end
        idle(2);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
